// File: rtl/timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank_pkg
// Description : Shared constants for the timer bank: peripheral write
//               addresses, CONTROL bit positions and a channel-select width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_bank_pkg;

    // Peripheral write-port register addresses
    localparam logic [1:0] ADDR_PERIOD   = 2'd0;
    localparam logic [1:0] ADDR_CONTROL  = 2'd1;
    localparam logic [1:0] ADDR_ACK      = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    // CONTROL register bit positions
    localparam int CTL_EN   = 0;
    localparam int CTL_MODE = 1;
    localparam int CTL_IRQ  = 2;

    // Channel-select width; a single-channel bank still needs a 1-bit select
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_bank_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One timer channel: period/count registers, enable, mode,
//               interrupt enable and a sticky pending flag. Counts on the
//               shared prescaler tick and pulses line_o on terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tick_i,
    input  logic            period_we_i,
    input  logic            control_we_i,
    input  logic            ack_i,
    input  logic [BITS-1:0] wdata_i,
    output logic            line_o,
    output logic            pending_o,
    output logic            irq_req_o,
    output logic [BITS-1:0] count_o
);

    logic [BITS-1:0] period_q, period_d;
    logic [BITS-1:0] count_q,  count_d;
    logic            en_q,     en_d;
    logic            mode_q,   mode_d;
    logic            irq_en_q, irq_en_d;
    logic            pending_q, pending_d;
    logic            line_q,   line_d;
    logic            expire;

    assign expire = tick_i && en_q && (count_q == period_q);

    // Next-state: PERIOD write outranks counting; CONTROL write outranks one-shot self-clear
    always_comb begin
        period_d  = period_q;
        count_d   = count_q;
        en_d      = en_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
        line_d    = 1'b0;

        // ACK clears first so that a coincident expiry re-sets pending
        if (ack_i) begin
            pending_d = 1'b0;
        end

        if (period_we_i) begin
            period_d = wdata_i;
            count_d  = '0;
        end else if (tick_i && en_q) begin
            if (expire) begin
                count_d   = '0;
                line_d    = 1'b1;
                pending_d = 1'b1;
                if (mode_q) begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if (control_we_i) begin
            en_d     = wdata_i[CTL_EN];
            mode_d   = wdata_i[CTL_MODE];
            irq_en_d = wdata_i[CTL_IRQ];
        end
    end

    // Channel state registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            period_q  <= '0;
            count_q   <= '0;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            line_q    <= 1'b0;
        end else begin
            period_q  <= period_d;
            count_q   <= count_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            line_q    <= line_d;
        end
    end

    assign line_o    = line_q;
    assign pending_o = pending_q;
    assign irq_req_o = pending_q & irq_en_q;
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank
// Description : Multi-channel programmable timer. Shared prescaler, write
//               decode, CHANNELS timer_channel instances, combined level
//               interrupt and registered count readback.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BITS     = 32,
    parameter int PRE_BITS = 8,
    localparam int CH_W    = chan_width(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [1:0]          wr_addr,
    input  logic [BITS-1:0]     wr_data,
    input  logic [CH_W-1:0]     rd_chan,
    output logic [BITS-1:0]     rd_count,
    output logic [CHANNELS-1:0] line,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
);

    logic [PRE_BITS-1:0] prescale_q, prescale_d;
    logic [PRE_BITS-1:0] pre_cnt_q,  pre_cnt_d;
    logic [BITS-1:0]     rd_count_q, rd_count_d;
    logic                tick;
    logic [CHANNELS-1:0] irq_req;
    logic [BITS-1:0]     chan_count [CHANNELS];

    assign tick = (pre_cnt_q == prescale_q);

    // Prescaler next-state; a PRESCALE write restarts the divider
    always_comb begin
        prescale_d = prescale_q;
        pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
        if (wr_en && (wr_addr == ADDR_PRESCALE)) begin
            prescale_d = wr_data[PRE_BITS-1:0];
            pre_cnt_d  = '0;
        end
    end

    // Readback mux; an out-of-range select returns zero
    always_comb begin
        rd_count_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_chan == CH_W'(k)) begin
                rd_count_d = chan_count[k];
            end
        end
    end

    // Prescaler and readback registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            rd_count_q <= '0;
        end else begin
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            rd_count_q <= rd_count_d;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            logic period_we;
            logic control_we;
            logic ack;

            assign period_we  = wr_en && (wr_addr == ADDR_PERIOD)  && (wr_chan == CH_W'(i));
            assign control_we = wr_en && (wr_addr == ADDR_CONTROL) && (wr_chan == CH_W'(i));
            assign ack        = wr_en && (wr_addr == ADDR_ACK)     && wr_data[i];

            timer_channel #(
                .BITS (BITS)
            ) u_chan (
                .clock        (clock),
                .reset        (reset),
                .tick_i       (tick),
                .period_we_i  (period_we),
                .control_we_i (control_we),
                .ack_i        (ack),
                .wdata_i      (wr_data),
                .line_o       (line[i]),
                .pending_o    (pending[i]),
                .irq_req_o    (irq_req[i]),
                .count_o      (chan_count[i])
            );
        end
    endgenerate

    assign irq      = |irq_req;
    assign rd_count = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_bank
// Description : Self-checking bench for timer_bank: directed scenarios plus
//               randomized register writes compared every cycle against a
//               cycle-level reference model of the timer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

    localparam int CH   = 4;
    localparam int BITS = 32;
    localparam int PB   = 8;
    localparam int CW   = 2;

    logic            clock   = 1'b0;
    logic            reset   = 1'b0;
    logic            wr_en   = 1'b0;
    logic [CW-1:0]   wr_chan = '0;
    logic [1:0]      wr_addr = '0;
    logic [BITS-1:0] wr_data = '0;
    logic [CW-1:0]   rd_chan = '0;
    logic [BITS-1:0] rd_count;
    logic [CH-1:0]   line;
    logic [CH-1:0]   pending;
    logic            irq;

    timer_bank #(.CHANNELS(CH), .BITS(BITS), .PRE_BITS(PB)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_chan  (wr_chan),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_chan  (rd_chan),
        .rd_count (rd_count),
        .line     (line),
        .pending  (pending),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [BITS-1:0] m_period [CH];
    logic [BITS-1:0] m_count  [CH];
    bit              m_en     [CH];
    bit              m_mode   [CH];
    bit              m_ie     [CH];
    logic [CH-1:0]   m_pend;
    logic [CH-1:0]   m_line;
    logic [PB-1:0]   m_pre;
    logic [PB-1:0]   m_pcnt;
    logic [BITS-1:0] m_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [CW-1:0] rd_sel = '0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply one clock edge worth of the timer rules to the model
    function automatic void model_step();
        bit tick;
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                m_period[i] = '0; m_count[i] = '0;
                m_en[i] = 0; m_mode[i] = 0; m_ie[i] = 0;
            end
            m_pend = '0; m_line = '0; m_pre = '0; m_pcnt = '0; m_rd = '0;
            return;
        end
        tick = (m_pcnt == m_pre);
        m_rd = m_count[rd_chan];
        m_pcnt = tick ? '0 : m_pcnt + 1'b1;
        if (wr_en && wr_addr == 2'd3) begin
            m_pre  = wr_data[PB-1:0];
            m_pcnt = '0;
        end
        for (int i = 0; i < CH; i++) begin
            bit pw, cw, ak;
            pw = wr_en && wr_addr == 2'd0 && int'(wr_chan) == i;
            cw = wr_en && wr_addr == 2'd1 && int'(wr_chan) == i;
            ak = wr_en && wr_addr == 2'd2 && wr_data[i];
            m_line[i] = 1'b0;
            if (ak) m_pend[i] = 1'b0;
            if (pw) begin
                m_period[i] = wr_data;
                m_count[i]  = '0;
            end else if (tick && m_en[i]) begin
                if (m_count[i] == m_period[i]) begin
                    m_count[i] = '0;
                    m_line[i]  = 1'b1;
                    m_pend[i]  = 1'b1;
                    if (m_mode[i]) m_en[i] = 0;
                end else begin
                    m_count[i] = m_count[i] + 1;
                end
            end
            if (cw) begin
                m_en[i]   = wr_data[0];
                m_mode[i] = wr_data[1];
                m_ie[i]   = wr_data[2];
            end
        end
    endfunction

    function automatic logic model_irq();
        logic r = 1'b0;
        for (int i = 0; i < CH; i++) r |= m_pend[i] & m_ie[i];
        return r;
    endfunction

    // One clock cycle: drive on the falling edge, model at the rising edge, compare 1 time unit later
    task automatic step(input logic rst_n, input logic we, input logic [1:0] addr,
                        input logic [CW-1:0] ch, input logic [BITS-1:0] data);
        @(negedge clock);
        reset = rst_n; wr_en = we; wr_addr = addr; wr_chan = ch; wr_data = data; rd_chan = rd_sel;
        @(posedge clock);
        model_step();
        #1;
        cyc++;
        check_value("line",     line,     m_line);
        check_value("pending",  pending,  m_pend);
        check_value("irq",      irq,      model_irq());
        check_value("rd_count", rd_count, m_rd);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'd0, '0, '0);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [CW-1:0] ch, input logic [BITS-1:0] data);
        step(1'b1, 1'b1, addr, ch, data);
    endtask

    // Cycles between two consecutive line pulses on one channel, -1 if none within budget
    task automatic measure(input int ch, input int budget, output int interval);
        int seen = 0;
        int t0   = 0;
        interval = -1;
        for (int k = 0; k < budget && seen < 2; k++) begin
            idle();
            if (line[ch]) begin
                if (seen == 0) t0 = k;
                else interval = k - t0;
                seen++;
            end
        end
    endtask

    // Advance until the model says the next edge is a terminal-count tick for ch
    task automatic wait_expiry(input int ch, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (m_pcnt == m_pre && m_en[ch] && m_count[ch] == m_period[ch]) begin
                ok = 1;
                break;
            end
            idle();
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, '0, '0);
        idle();
    endtask

    initial begin
        int iv;
        int pulses;
        bit ok;
        logic [BITS-1:0] held;

        // Reset from power-up
        do_reset(3);
        check_value("reset_line", line, '0);
        check_value("reset_pending", pending, '0);
        check_value("reset_irq", irq, 1'b0);

        // Periodic: prescale 0, ch0 period 4
        rd_sel = 2'd0;
        wr(2'd3, '0, 32'd0);
        wr(2'd0, 2'd0, 32'd4);
        wr(2'd1, 2'd0, 32'h1);
        measure(0, 40, iv);
        check_value("periodic_interval", iv, (4 + 1) * (0 + 1));

        // Prescaler: prescale 2, ch1 period 1
        rd_sel = 2'd1;
        wr(2'd3, '0, 32'd2);
        wr(2'd0, 2'd1, 32'd1);
        wr(2'd1, 2'd1, 32'h1);
        measure(1, 60, iv);
        check_value("prescale_interval", iv, (1 + 1) * (2 + 1));
        idle();
        wr(2'd3, '0, 32'd2);
        measure(1, 60, iv);
        check_value("prescale_after_rewrite", iv, 6);

        // One-shot with interrupt on ch2
        rd_sel = 2'd2;
        wr(2'd0, 2'd2, 32'd3);
        wr(2'd1, 2'd2, 32'h7);
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            idle();
            if (line[2]) pulses++;
        end
        check_value("oneshot_pulses", pulses, 1);
        check_value("oneshot_irq", irq, 1'b1);
        wr(2'd2, '0, 32'h4);
        check_value("oneshot_ack_irq", irq, 1'b0);

        // Simultaneous events on ch0
        do_reset(2);
        rd_sel = 2'd0;
        wr(2'd0, 2'd0, 32'd4);
        wr(2'd1, 2'd0, 32'h1);
        wait_expiry(0, 40, ok);
        check_value("wait_expiry_ack", ok, 1'b1);
        wr(2'd2, '0, 32'h1);
        check_value("ack_vs_expiry_pending", pending[0], 1'b1);
        check_value("ack_vs_expiry_line", line[0], 1'b1);
        wait_expiry(0, 40, ok);
        check_value("wait_expiry_period", ok, 1'b1);
        wr(2'd0, 2'd0, 32'd4);
        check_value("period_vs_expiry_line", line[0], 1'b0);
        idle();
        check_value("period_vs_expiry_count", rd_count, 32'd0);

        // Independence: periods 0..3 on channels 0..3
        do_reset(2);
        for (int i = 0; i < CH; i++) begin
            wr(2'd0, CW'(i), BITS'(i));
            wr(2'd1, CW'(i), 32'h1);
        end
        for (int i = 0; i < CH; i++) begin
            measure(i, 40, iv);
            check_value($sformatf("indep_interval_ch%0d", i), iv, i + 1);
        end
        rd_sel = 2'd3;
        wr(2'd1, 2'd3, 32'h0);
        idle();
        idle();
        held = m_count[3];
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (line[3]) pulses++;
        end
        check_value("disabled_pulses", pulses, 0);
        check_value("disabled_hold", rd_count, held);

        // Reset mid-count
        do_reset(3);
        check_value("midreset_line", line, '0);
        check_value("midreset_pending", pending, '0);
        check_value("midreset_irq", irq, 1'b0);
        check_value("midreset_rd", rd_count, '0);

        // Randomized register traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [1:0] a;
            logic [BITS-1:0] d;
            r = $urandom_range(0, 99);
            rd_sel = CW'($urandom_range(0, CH - 1));
            if (r < 1) begin
                step(1'b0, 1'b0, 2'd0, '0, '0);
            end else if (r < 25) begin
                a = 2'($urandom_range(0, 3));
                case (a)
                    2'd0:    d = BITS'($urandom_range(0, 9));
                    2'd3:    d = BITS'($urandom_range(0, 3));
                    default: d = $urandom;
                endcase
                wr(a, CW'($urandom_range(0, CH - 1)), d);
            end else begin
                idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
